// File: rtl/out_ser_pkg.sv
// Shared types, constants and helpers for the word-to-byte UART serializer.
// The OUT_SER_OVF_CNT_EN build option lives in the top level.
package out_ser_pkg;

  typedef logic [1:0] ser_state_t;

  localparam ser_state_t WAIT_WORD = 2'd0;
  localparam ser_state_t SEND      = 2'd1;
  localparam ser_state_t GAP       = 2'd2;
  localparam ser_state_t WAIT_RDY  = 2'd3;

  localparam int OVF_CNT_W = 16;

  function automatic int byte_pos(
    input int idx,
    input int nbytes,
    input bit lsb_first
  );
    return lsb_first ? idx : nbytes - 1 - idx;
  endfunction

endpackage

// File: rtl/ser_word_fifo.sv
// Synchronous word FIFO with registered q and registered full/empty flags.
// A write while full is accepted only when a read happens in the same cycle.
module ser_word_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] q,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          do_wr;
  logic          do_rd;

  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign cnt_nxt = cnt + CW'(do_wr) - CW'(do_rd);

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      q      <= '0;
    end else begin
      cnt   <= cnt_nxt;
      full  <= cnt_nxt == CW'(DEPTH);
      empty <= cnt_nxt == '0;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        q      <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/output_serializer_uart.sv
// Buffers datapath words and emits them byte-by-byte to a UART transmitter.
// Define OUT_SER_OVF_CNT_EN to add the saturating ovf_cnt dropped-word counter.
module output_serializer_uart
  import out_ser_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int FIFO_DEPTH = 16,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [8*WORD_BYTES-1:0]       DATA,
  input  logic                          ENA,
  input  logic [$clog2(WORD_BYTES)-1:0] LAST_BYTES,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  output logic                          fifo_full,
  output logic                          ovf,
`ifdef OUT_SER_OVF_CNT_EN
  output logic [OVF_CNT_W-1:0]          ovf_cnt,
`endif
  output logic [1:0]                    state_mon
);

  localparam int IW = $clog2(WORD_BYTES);
  localparam int NW = IW + 1;
  localparam int DW = 8 * WORD_BYTES;

  ser_state_t      state;
  logic [IW-1:0]   byte_idx;
  logic            loaded;
  logic            empty;
  logic            rd;
  logic            drop;
  logic            last_byte;
  logic [DW-1:0]   word_q;
  logic [IW-1:0]   lb_q;
  logic [NW-1:0]   n_bytes;

  ser_word_fifo #(
    .W     (IW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .wr_en (ENA),
    .din   ({LAST_BYTES, DATA}),
    .rd_en (rd),
    .q     ({lb_q, word_q}),
    .full  (fifo_full),
    .empty (empty)
  );

  assign rd        = (state == WAIT_WORD) && !empty;
  assign drop      = ENA && fifo_full && !rd;
  assign n_bytes   = (lb_q == '0) ? NW'(WORD_BYTES) : {1'b0, lb_q};
  assign last_byte = ({1'b0, byte_idx} + NW'(1)) == n_bytes;
  assign state_mon = state;

  always_comb begin
    tx_data = 8'(word_q >> (8 * byte_pos(int'(byte_idx), WORD_BYTES, LSB_FIRST)));
  end

  // loaded keeps the post-reset ready check from emitting a byte of q=0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= GAP;
      byte_idx <= '0;
      tx_valid <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      unique case (state)
        WAIT_WORD: begin
          if (!empty) begin
            byte_idx <= '0;
            loaded   <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_valid <= 1'b1;
          state    <= GAP;
        end
        GAP: begin
          tx_valid <= 1'b0;
          state    <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (tx_ready) begin
            if (!loaded || last_byte) begin
              loaded <= 1'b0;
              state  <= WAIT_WORD;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= SEND;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ovf <= 1'b0;
    else      ovf <= drop;
  end

`ifdef OUT_SER_OVF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ovf_cnt <= '0;
    else if (ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_output_serializer_uart.sv
// Self-checking bench for output_serializer_uart: two configurations,
// byte scoreboards fed at write time and drained on tx_valid.
module tb_output_serializer_uart;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // A: 2-byte words, MSB first, shallow FIFO
  logic [15:0] a_data;
  logic        a_ena;
  logic        a_lb;
  logic        a_rdy;
  logic [7:0]  a_txd;
  logic        a_txv;
  logic        a_full;
  logic        a_ovf;
  logic [1:0]  a_st;
`ifdef OUT_SER_OVF_CNT_EN
  logic [15:0] a_ovf_cnt;
  logic [15:0] b_ovf_cnt;
`endif

  // B: 4-byte words, LSB first
  logic [31:0] b_data;
  logic        b_ena;
  logic [1:0]  b_lb;
  logic        b_rdy;
  logic [7:0]  b_txd;
  logic        b_txv;
  logic        b_full;
  logic        b_ovf;
  logic [1:0]  b_st;

  output_serializer_uart #(
    .WORD_BYTES (2),
    .FIFO_DEPTH (4),
    .LSB_FIRST  (1'b0)
  ) dut_a (
    .CLK        (CLK),
    .RST        (RST),
    .DATA       (a_data),
    .ENA        (a_ena),
    .LAST_BYTES (a_lb),
    .tx_ready   (a_rdy),
    .tx_data    (a_txd),
    .tx_valid   (a_txv),
    .fifo_full  (a_full),
    .ovf        (a_ovf),
`ifdef OUT_SER_OVF_CNT_EN
    .ovf_cnt    (a_ovf_cnt),
`endif
    .state_mon  (a_st)
  );

  output_serializer_uart #(
    .WORD_BYTES (4),
    .FIFO_DEPTH (16),
    .LSB_FIRST  (1'b1)
  ) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .DATA       (b_data),
    .ENA        (b_ena),
    .LAST_BYTES (b_lb),
    .tx_ready   (b_rdy),
    .tx_data    (b_txd),
    .tx_valid   (b_txv),
    .fifo_full  (b_full),
    .ovf        (b_ovf),
`ifdef OUT_SER_OVF_CNT_EN
    .ovf_cnt    (b_ovf_cnt),
`endif
    .state_mon  (b_st)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lb;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t va[5];
  vec_t vb[4];

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  int         a_pc[$];
  int         a_ovfs = 0;
  logic       a_pv = 1'b0;
  logic       b_pv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (a_ovf) a_ovfs++;
    if (a_txv) begin
      a_pc.push_back(cyc);
      chk("a_pulse_width", 32'(a_pv), 32'd0);
      chk("a_byte_expected", 32'(a_q.size() != 0), 32'd1);
      if (a_q.size() != 0) chk("a_byte", 32'(a_txd), 32'(a_q.pop_front()));
    end
    a_pv = a_txv;
  end

  always @(negedge CLK) begin
    if (b_txv) begin
      chk("b_pulse_width", 32'(b_pv), 32'd0);
      chk("b_byte_expected", 32'(b_q.size() != 0), 32'd1);
      if (b_q.size() != 0) chk("b_byte", 32'(b_txd), 32'(b_q.pop_front()));
    end
    b_pv = b_txv;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((a_q.size() != 0 || b_q.size() != 0 || a_st != 2'd0 ||
            b_st != 2'd0) && k < 500) begin
      step();
      k++;
    end
    chk(name, 32'(k < 500), 32'd1);
  endtask

  task automatic put_a(input logic [15:0] d, input logic lb, input int n);
    a_data = d;
    a_lb   = lb;
    a_ena  = 1'b1;
    for (int j = 0; j < n; j++) begin
      logic [15:0] t;
      t = d;
      a_q.push_back(8'(t >> (8 * (1 - j))));
    end
  endtask

  task automatic wait_pulses(input int n, input string name);
    int k;
    k = 0;
    while (a_pc.size() < n && k < 50) begin
      step();
      k++;
    end
    chk(name, 32'(k < 50), 32'd1);
  endtask

  initial begin
    int c0;
    int chg;

    va[0] = '{32'h0000A55A, 2'd0, 2, 32'h00005AA5};
    va[1] = '{32'h00001234, 2'd1, 1, 32'h00000012};
    va[2] = '{32'h0000BEEF, 2'd0, 2, 32'h0000EFBE};
    va[3] = '{32'h000000FF, 2'd1, 1, 32'h00000000};
    va[4] = '{32'h0000C3D4, 2'd0, 2, 32'h0000D4C3};
    vb[0] = '{32'h44332211, 2'd3, 3, 32'h00332211};
    vb[1] = '{32'hDDCCBBAA, 2'd0, 4, 32'hDDCCBBAA};
    vb[2] = '{32'h00000077, 2'd1, 1, 32'h00000077};
    vb[3] = '{32'h89ABCDEF, 2'd2, 2, 32'h0000CDEF};

    a_data = '0; a_ena = 1'b0; a_lb = 1'b0; a_rdy = 1'b1;
    b_data = '0; b_ena = 1'b0; b_lb = 2'd0; b_rdy = 1'b1;
    step(2);

    chk("rst_tx_valid", 32'(a_txv), 32'd0);
    chk("rst_state", 32'(a_st), 32'd2);
    chk("rst_tx_data", 32'(a_txd), 32'd0);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_b_state", 32'(b_st), 32'd2);
`ifdef OUT_SER_OVF_CNT_EN
    chk("rst_ovf_cnt", 32'(a_ovf_cnt), 32'd0);
`endif

    RST = 1'b1;
    drain("boot_idle");

    // single word latency and byte spacing
    a_pc.delete();
    put_a(16'hA55A, 1'b0, 2);
    step();
    c0 = cyc;
    a_ena = 1'b0;
    drain("t1_drain");
    chk("t1_pulses", 32'(a_pc.size()), 32'd2);
    chk("t1_first_latency", 32'(a_pc[0] - c0), 32'd2);
    chk("t1_byte_period", 32'(a_pc[1] - a_pc[0]), 32'd3);

    // back-to-back table words on A
    a_pc.delete();
    foreach (va[i]) begin
      a_data = va[i].data[15:0];
      a_lb   = va[i].lb[0];
      a_ena  = 1'b1;
      for (int j = 0; j < va[i].n; j++) a_q.push_back(8'(va[i].exp >> (8 * j)));
      step();
    end
    a_ena = 1'b0;
    drain("tbl_a_drain");
    chk("tbl_a_pulses", 32'(a_pc.size()), 32'd8);
    chk("tbl_a_word_period", 32'(a_pc[2] - a_pc[0]), 32'd7);
    chk("tbl_a_short_word", 32'(a_pc[3] - a_pc[2]), 32'd4);
    chk("tbl_a_no_ovf", 32'(a_ovfs), 32'd0);

    // table words on B, LSB first with partials
    foreach (vb[i]) begin
      b_data = vb[i].data;
      b_lb   = vb[i].lb;
      b_ena  = 1'b1;
      for (int j = 0; j < vb[i].n; j++) b_q.push_back(8'(vb[i].exp >> (8 * j)));
      step();
    end
    b_ena = 1'b0;
    drain("tbl_b_drain");

    // tx_ready held low after the first byte
    a_pc.delete();
    put_a(16'h1357, 1'b0, 2);
    step();
    a_ena = 1'b0;
    wait_pulses(1, "hold_first");
    a_rdy = 1'b0;
    chg = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (a_txd !== 8'h13) chg++;
    end
    chk("hold_no_pulse", 32'(a_pc.size()), 32'd1);
    chk("hold_data_stable", 32'(chg), 32'd0);
    chk("hold_state", 32'(a_st), 32'd3);
    a_rdy = 1'b1;
    drain("hold_drain");
    chk("hold_release", 32'(a_pc.size()), 32'd2);

    // overflow: one pending word + four buffered, sixth dropped
    a_pc.delete();
    a_ovfs = 0;
    a_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_data = 16'hF0A0 + 16'(i);
      a_lb   = 1'b0;
      a_ena  = 1'b1;
      if (i < 5) put_a(16'hF0A0 + 16'(i), 1'b0, 2);
      step();
    end
    a_ena = 1'b0;
    step();
    chk("ovf_full", 32'(a_full), 32'd1);
    chk("ovf_pulses", 32'(a_ovfs), 32'd1);
    chk("ovf_pending_byte", 32'(a_pc.size()), 32'd1);
`ifdef OUT_SER_OVF_CNT_EN
    chk("ovf_cnt", 32'(a_ovf_cnt), 32'd1);
`endif
    a_rdy = 1'b1;
    drain("ovf_drain");
    chk("ovf_all_bytes", 32'(a_pc.size()), 32'd10);
    chk("ovf_full_clear", 32'(a_full), 32'd0);

    // reset in the middle of a word with another word queued
    a_pc.delete();
    put_a(16'h9ABC, 1'b0, 2);
    step();
    put_a(16'h1111, 1'b0, 0);
    step();
    a_ena = 1'b0;
    wait_pulses(1, "rst_mid_first");
    RST = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 32'(a_txv), 32'd0);
    chk("rst_mid_state", 32'(a_st), 32'd2);
    chk("rst_mid_full", 32'(a_full), 32'd0);
    a_q.delete();
    step(2);
    RST = 1'b1;
    step(20);
    chk("rst_mid_fifo_empty", 32'(a_pc.size()), 32'd1);
    put_a(16'h2468, 1'b0, 2);
    step();
    a_ena = 1'b0;
    drain("rst_after_drain");
    chk("rst_after_pulses", 32'(a_pc.size()), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
